mdu: RTL and testbench
======================

Name: mdu

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, for the next-generation MIPS core; instantiated beside the ALU in the execute stage.
- Accepts one operation at a time and stalls the pipeline through `busy` while an operation is in flight.
- Generalises the combinational ALU with configurable width, independent multiply/divide latencies, and a completion pulse.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥ 2).
- MULT_CYCLES, 5, cycles from accepted multiply to result (≥ 1).
- DIV_CYCLES, 10, cycles from accepted divide to result (≥ 1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request strobe, sampled on rising edge
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 reserved
- a  input  WIDTH  operand A (rs): multiplicand, dividend, or MTHI/MTLO data
- b  input  WIDTH  operand B (rt): multiplier or divisor
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse, HI/LO just updated by MULT/MULTU/DIV/DIVU
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: the edge with reset=1 forces busy=0, done=0, hi=0, lo=0 and clears the internal counter. Reset mid-operation aborts the operation; no result is ever written.
- States: IDLE and RUN.
- IDLE, start=1, op∈{0..3}, accepted on edge T:
  - Latch a, b and op.
  - Load counter with N−1, where N = MULT_CYCLES or DIV_CYCLES.
  - Enter RUN; busy=1 from T.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==0: write hi/lo, pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles; the result is visible on hi/lo in the cycle after the N-th edge from acceptance.
- IDLE, start=1, op=4 (MTHI): hi←a on that edge. op=5 (MTLO): lo←a on that edge. busy and done stay 0.
- Reserved op (6/7) with start=1: ignored, no state change.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO; a, b and op changes have no effect. The core must stall on busy.
- hi/lo hold their previous values during RUN; reads during RUN return the old values.
- Arithmetic:
  - MULTU: {hi,lo} = a×b unsigned, full 2·WIDTH product.
  - MULT: same, two's-complement signed.
  - DIVU: lo = a/b, hi = a%b, unsigned.
  - DIV: signed; quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV with a = −2^(WIDTH−1), b = −1: lo = −2^(WIDTH−1), hi = 0.
  - DIV/DIVU with b=0: runs the full DIV_CYCLES, busy and done behave normally, hi/lo remain unchanged.
- Result computation: either iterative or a single combinational result registered at completion; only the cycle timing above is visible.
- start in the same cycle done pulses: the unit is still busy on that edge, so the request is ignored; it is accepted one cycle later.

Test Plan:
- Reset, then MTHI a=0x12345678 → hi=0x12345678 next cycle. Then MTLO a=0xCAFEBABE → lo=0xCAFEBABE. busy and done stay 0 throughout.
- MULT a=0xFFFFFFFE (−2), b=3 → busy high exactly 5 cycles, done one pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=5, b=0 with prior hi=lo=0xAAAAAAAA → both stay 0xAAAAAAAA, done still pulses after 10 cycles.
- MULTU 3×4 accepted; on cycle 2 drive MTLO a=0x1 and a second MULTU 9×9 → both ignored, lo=12, hi=0, exactly one done pulse.
- MULTU started; reset asserted on cycle 3 → busy=0, hi=lo=0, no done pulse. Then MULTU 2×2 completes normally: lo=4, with parameters overridden to MULT_CYCLES=1 so busy lasts 1 cycle.

Source files
------------

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
//
// Takes one operation at a time. MULT/MULTU/DIV/DIVU latch their operands and hold
// busy for exactly MULT_CYCLES or DIV_CYCLES cycles. HI/LO are written on the final
// edge, and done pulses for one cycle. MTHI/MTLO write HI/LO directly from idle.
// Requests made while busy are dropped, so the core has to stall on busy.
//
// Ports:
//   clk    in   clock, rising-edge
//   reset  in   synchronous, active-high; aborts any in-flight operation
//   start  in   request strobe
//   op     in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 ignored)
//   a      in   multiplicand / dividend / MTHI-MTLO data
//   b      in   multiplier / divisor
//   busy   out  operation in flight
//   done   out  one-cycle pulse: HI/LO were just written by a multiply or divide
//   hi     out  HI register
//   lo     out  LO register
module mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    // The result is computed combinationally from the latched operands and is only
    // registered on the final edge. Only the cycle timing is visible outside.
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    always_comb begin
        a_ext = {{WIDTH{is_signed_q & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{is_signed_q & b_q[WIDTH-1]}}, b_q};
        // Sign extension makes the low 2*WIDTH bits of the product correct for signed operands too.
        prod  = a_ext * b_ext;

        a_neg  = is_signed_q & a_q[WIDTH-1];
        b_neg  = is_signed_q & b_q[WIDTH-1];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        // The division result for a zero divisor is discarded. This substitute only avoids X.
        b_safe = (b_q == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        // Magnitude division gives truncation toward zero and a dividend-signed remainder.
        // For -2^(W-1) / -1 the quotient wraps back to -2^(W-1).
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d         = a;
                            b_d         = b;
                            is_div_d    = op[1];
                            is_signed_d = ~op[0];
                            cnt_d       = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                            state_d     = StRun;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu. The main instance uses the default parameters. A second instance
// (WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3) covers the width and latency overrides.
// Expected HI/LO come from a plain-arithmetic reference model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start_s;
    logic [2:0]  op_s;
    logic [7:0]  a_s, b_s;
    logic        busy_s, done_s;
    logic [7:0]  hi_s, lo_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    mdu #(
        .WIDTH       (8),
        .MULT_CYCLES (1),
        .DIV_CYCLES  (3)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .op    (op_s),
        .a     (a_s),
        .b     (b_s),
        .busy  (busy_s),
        .done  (done_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // Reference model for one operation at width w (w <= 32), written as plain arithmetic.
    function automatic void ref_op(input int w, input int o, input longint unsigned x,
                                   input longint unsigned y, inout longint unsigned h,
                                   inout longint unsigned l);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint          sx, sy, q, r;
        longint unsigned p;
        sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        case (o)
            0: begin p = longint'(sx * sy); h = (p >> w) & mask; l = p & mask; end
            1: begin p = x * y;             h = (p >> w) & mask; l = p & mask; end
            2: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                l = longint'(q) & mask;
                h = longint'(r) & mask;
            end
            3: if (y != 0) begin l = x / y; h = x % y; end
            4: h = x;
            5: l = x;
            default: ;
        endcase
    endfunction

    // Issue one request to the main instance and watch 16 post-edge samples, starting with the accept edge.
    task automatic op_main(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int nb, output int nd);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        nb = 0; nd = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy) nb++;
            if (done) nd++;
            @(posedge clk); #1;
        end
    endtask

    task automatic op_small(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                            output int nb, output int nd);
        @(negedge clk);
        start_s = 1'b1; op_s = o; a_s = x; b_s = y;
        @(posedge clk); #1;
        start_s = 1'b0; a_s = 8'($urandom); b_s = 8'($urandom);
        nb = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_s) nb++;
            if (done_s) nd++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hFFFF_FFFF; b = 32'h1;
        start_s = 1'b1; op_s = 3'd5; a_s = 8'hFF; b_s = 8'h1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_main got busy=%0b done=%0b hi=%h lo=%h want all zero", busy, done, hi, lo);
        end
        checks++;
        if ({busy_s, done_s, hi_s, lo_s} !== 18'd0) begin
            failures++;
            $display("FAIL reset_small got busy=%0b done=%0b hi=%h lo=%h want all zero",
                     busy_s, done_s, hi_s, lo_s);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; start_s = 1'b0;
    endtask

    task automatic test_mtx;
        int nb, nd;
        op_main(3'd4, 32'h1234_5678, 32'h0, nb, nd);
        checks++;
        if (hi !== 32'h1234_5678 || nb != 0 || nd != 0) begin
            failures++;
            $display("FAIL mthi got hi=%h busy=%0d done=%0d want hi=12345678 busy=0 done=0", hi, nb, nd);
        end
        op_main(3'd5, 32'hCAFE_BABE, 32'h0, nb, nd);
        checks++;
        if (lo !== 32'hCAFE_BABE || hi !== 32'h1234_5678 || nb != 0 || nd != 0) begin
            failures++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%0d done=%0d want 12345678 cafebabe 0 0",
                     hi, lo, nb, nd);
        end
    endtask

    task automatic test_mult;
        int nb, nd;
        op_main(3'd0, 32'hFFFF_FFFE, 32'd3, nb, nd);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || nb != 5 || nd != 1) begin
            failures++;
            $display("FAIL mult got hi=%h lo=%h busy=%0d done=%0d want ffffffff fffffffa 5 1",
                     hi, lo, nb, nd);
        end
        op_main(3'd1, 32'hFFFF_FFFE, 32'd3, nb, nd);
        checks++;
        if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA || nb != 5 || nd != 1) begin
            failures++;
            $display("FAIL multu got hi=%h lo=%h busy=%0d done=%0d want 00000002 fffffffa 5 1",
                     hi, lo, nb, nd);
        end
    endtask

    task automatic test_div;
        int nb, nd;
        op_main(3'd2, 32'hFFFF_FFF9, 32'd2, nb, nd);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD || nb != 10 || nd != 1) begin
            failures++;
            $display("FAIL div got hi=%h lo=%h busy=%0d done=%0d want ffffffff fffffffd 10 1",
                     hi, lo, nb, nd);
        end
        op_main(3'd3, 32'd7, 32'd2, nb, nd);
        checks++;
        if (hi !== 32'd1 || lo !== 32'd3 || nb != 10 || nd != 1) begin
            failures++;
            $display("FAIL divu got hi=%h lo=%h busy=%0d done=%0d want 1 3 10 1", hi, lo, nb, nd);
        end
    endtask

    task automatic test_div_edge;
        int nb, nd;
        op_main(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000 || nd != 1) begin
            failures++;
            $display("FAIL div_overflow got hi=%h lo=%h done=%0d want 0 80000000 1", hi, lo, nd);
        end
        op_main(3'd4, 32'hAAAA_AAAA, 32'd0, nb, nd);
        op_main(3'd5, 32'hAAAA_AAAA, 32'd0, nb, nd);
        op_main(3'd3, 32'd5, 32'd0, nb, nd);
        checks++;
        if (hi !== 32'hAAAA_AAAA || lo !== 32'hAAAA_AAAA || nb != 10 || nd != 1) begin
            failures++;
            $display("FAIL div_by_zero got hi=%h lo=%h busy=%0d done=%0d want aaaaaaaa aaaaaaaa 10 1",
                     hi, lo, nb, nd);
        end
    endtask

    // MULTU 3x4 in flight. An MTLO and a second MULTU arrive mid-run and must both be dropped.
    task automatic test_busy_ignore;
        int nd = 0;
        logic [31:0] mid_hi, mid_lo;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        if (done) nd++;
        @(negedge clk);
        op = 3'd5; a = 32'd1; b = 32'd0;
        @(posedge clk); #1;
        if (done) nd++;
        @(negedge clk);
        op = 3'd1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        mid_hi = hi; mid_lo = lo;
        if (done) nd++;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        checks++;
        if (mid_hi !== 32'hAAAA_AAAA || mid_lo !== 32'hAAAA_AAAA) begin
            failures++;
            $display("FAIL hold_during_run got hi=%h lo=%h want aaaaaaaa aaaaaaaa", mid_hi, mid_lo);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd12 || nd != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore got hi=%h lo=%h done=%0d busy=%0b want 0 c 1 0", hi, lo, nd, busy);
        end
    endtask

    // start held high: the request seen on the completion edge is dropped and is taken one edge later.
    task automatic test_back_to_back;
        logic [19:0] btr, dtr;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            btr[i] = busy;
            dtr[i] = done;
            if (i == 6) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (btr !== 20'h007DF) begin
            failures++;
            $display("FAIL b2b_busy got trace=%h want 007df", btr);
        end
        checks++;
        if (dtr !== 20'h00820 || lo !== 32'd6 || hi !== 32'd0) begin
            failures++;
            $display("FAIL b2b_done got trace=%h lo=%h hi=%h want 00820 6 0", dtr, lo, hi);
        end
    endtask

    task automatic test_reset_abort;
        int nd = 0, nb = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort got busy=%0b done=%0b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
            if (busy) nb++;
        end
        checks++;
        if (nd != 0 || nb != 0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL abort_no_result got done=%0d busy=%0d lo=%h want 0 0 0", nd, nb, lo);
        end
    endtask

    task automatic test_small;
        int nb, nd;
        op_small(3'd1, 8'd2, 8'd2, nb, nd);
        checks++;
        if (lo_s !== 8'd4 || hi_s !== 8'd0 || nb != 1 || nd != 1) begin
            failures++;
            $display("FAIL small_multu got hi=%h lo=%h busy=%0d done=%0d want 0 4 1 1", hi_s, lo_s, nb, nd);
        end
    endtask

    task automatic test_random_small;
        longint unsigned mh = 0, ml = 4;
        int nb, nd, o, eb, ed;
        logic [7:0] x, y;
        for (int n = 0; n < 30; n++) begin
            o = $urandom_range(0, 7);
            x = 8'($urandom);
            y = 8'($urandom);
            case ($urandom_range(0, 5))
                0: y = 8'd0;
                1: begin x = 8'h80; y = 8'hFF; end
                default: ;
            endcase
            ref_op(8, o, longint'(x), longint'(y), mh, ml);
            eb = (o <= 1) ? 1 : (o <= 3) ? 3 : 0;
            ed = (o <= 3) ? 1 : 0;
            op_small(3'(o), x, y, nb, nd);
            checks++;
            if (hi_s !== 8'(mh) || lo_s !== 8'(ml) || nb != eb || nd != ed) begin
                failures++;
                $display("FAIL rand_small op=%0d a=%h b=%h got hi=%h lo=%h busy=%0d done=%0d want %h %h %0d %0d",
                         o, x, y, hi_s, lo_s, nb, nd, 8'(mh), 8'(ml), eb, ed);
            end
        end
    endtask

    task automatic test_random_main;
        longint unsigned mh = 64'h0BAD_F00D, ml = 64'h1357_9BDF;
        int nb, nd, o, eb, ed;
        logic [31:0] x, y;
        op_main(3'd4, 32'h0BAD_F00D, 32'd0, nb, nd);
        op_main(3'd5, 32'h1357_9BDF, 32'd0, nb, nd);
        for (int n = 0; n < 40; n++) begin
            o = $urandom_range(0, 7);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: ;
            endcase
            ref_op(32, o, longint'(x), longint'(y), mh, ml);
            eb = (o <= 1) ? 5 : (o <= 3) ? 10 : 0;
            ed = (o <= 3) ? 1 : 0;
            op_main(3'(o), x, y, nb, nd);
            checks++;
            if (hi !== 32'(mh) || lo !== 32'(ml) || nb != eb || nd != ed) begin
                failures++;
                $display("FAIL rand_main op=%0d a=%h b=%h got hi=%h lo=%h busy=%0d done=%0d want %h %h %0d %0d",
                         o, x, y, hi, lo, nb, nd, 32'(mh), 32'(ml), eb, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mtx();
        test_mult();
        test_div();
        test_div_edge();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_small();
        test_random_small();
        test_random_main();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
